// File: rtl/matmul_pkg.sv
// Shared constants, header layout and loader state encoding for the matmul front end.
package matmul_pkg;

    localparam int unsigned TYPE_BW     = 16;
    localparam int unsigned IN_MEM_SIZE = 64;
    localparam int unsigned PTR_W       = $clog2(IN_MEM_SIZE);
    localparam int unsigned NEED_W      = 32;
    localparam int unsigned MEM_W       = TYPE_BW * IN_MEM_SIZE;

    // Header word offsets inside the operand memory
    localparam int unsigned HDR_OP = 0;
    localparam int unsigned HDR_WA = 1;
    localparam int unsigned HDR_HA = 2;
    localparam int unsigned HDR_WB = 3;
    localparam int unsigned HDR_HB = 4;
    localparam int unsigned HDR_GO = 5;
    localparam int unsigned A_BASE = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_KICK = 3'd3,
        ST_RUN  = 3'd4,
        ST_REL  = 3'd5,
        ST_ERR  = 3'd6
    } loader_state_e;

    // Total job length in words: header plus both operand matrices
    function automatic logic [NEED_W-1:0] calc_need(
        input logic [TYPE_BW-1:0] wa,
        input logic [TYPE_BW-1:0] ha,
        input logic [TYPE_BW-1:0] wb,
        input logic [TYPE_BW-1:0] hb
    );
        return NEED_W'(A_BASE) + NEED_W'(wa) * NEED_W'(ha) + NEED_W'(wb) * NEED_W'(hb);
    endfunction

endpackage

// File: rtl/matmul_operand_loader.sv
// Streams a matmul job (header + A + B) into the flat operand memory, kicks the
// engine once the payload is complete, waits for done, and flags framing errors.
module matmul_operand_loader
    import matmul_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [TYPE_BW-1:0] s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [MEM_W-1:0]   mem_o,
    output logic               mm_enable,
    input  logic               mm_done,
    output logic               busy,
    output logic               err,
    input  logic               clear_err
);

    loader_state_e      state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [TYPE_BW-1:0] mem_q [IN_MEM_SIZE];
    logic [TYPE_BW-1:0] mem_d [IN_MEM_SIZE];
    logic               s_ready_q, s_ready_d;
    logic               mm_enable_q, mm_enable_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic               accept;
    logic               wr_en;
    logic               at_final;
    logic [NEED_W-1:0]  need;

    // Job length from the registered size words; only meaningful once word 4 is stored
    assign need     = calc_need(mem_q[HDR_WA], mem_q[HDR_HA], mem_q[HDR_WB], mem_q[HDR_HB]);
    assign at_final = (NEED_W'(wr_ptr_q) == need - NEED_W'(1));

    // Next-state, memory write and registered-output decode
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
        wr_en    = 1'b0;
        accept   = s_valid && s_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (s_last) begin
                        state_d = ST_ERR;
                    end else begin
                        wr_en   = 1'b1;
                        state_d = ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                if (wr_ptr_q == PTR_W'(HDR_GO) && need > NEED_W'(IN_MEM_SIZE)) begin
                    // Oversized job: abort even if the go word is on the bus
                    state_d = ST_ERR;
                end else if (accept) begin
                    if (wr_ptr_q == PTR_W'(HDR_GO)) begin
                        if (need == NEED_W'(A_BASE)) begin
                            if (s_last) begin
                                wr_en   = 1'b1;
                                state_d = ST_KICK;
                            end else begin
                                state_d = ST_ERR;
                            end
                        end else if (s_last) begin
                            state_d = ST_ERR;
                        end else begin
                            wr_en   = 1'b1;
                            state_d = ST_LOAD;
                        end
                    end else if (s_last) begin
                        state_d = ST_ERR;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (at_final) begin
                        if (s_last) begin
                            wr_en   = 1'b1;
                            state_d = ST_KICK;
                        end else begin
                            state_d = ST_ERR;
                        end
                    end else if (s_last) begin
                        state_d = ST_ERR;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            ST_KICK: begin
                if (!mm_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mm_done) begin
                    state_d = ST_REL;
                end
            end
            ST_REL: begin
                state_d  = ST_IDLE;
                wr_ptr_d = '0;
            end
            ST_ERR: begin
                if (clear_err) begin
                    state_d  = ST_IDLE;
                    wr_ptr_d = '0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                wr_ptr_d = '0;
            end
        endcase

        if (wr_en) begin
            mem_d[wr_ptr_q] = s_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        s_ready_d   = (state_d == ST_IDLE) || (state_d == ST_HDR) ||
                      (state_d == ST_LOAD) || (state_d == ST_ERR);
        mm_enable_d = (state_d == ST_KICK) || (state_d == ST_RUN);
        busy_d      = (state_d == ST_HDR)  || (state_d == ST_LOAD) ||
                      (state_d == ST_KICK) || (state_d == ST_RUN)  || (state_d == ST_REL);
        err_d       = (state_d == ST_ERR);
    end

    // State, pointer, operand memory and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            mem_q       <= '{default: '0};
            s_ready_q   <= 1'b1;
            mm_enable_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            mem_q       <= mem_d;
            s_ready_q   <= s_ready_d;
            mm_enable_q <= mm_enable_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    for (genvar gi = 0; gi < IN_MEM_SIZE; gi++) begin : g_mem_o
        assign mem_o[gi*TYPE_BW +: TYPE_BW] = mem_q[gi];
    end

    assign s_ready   = s_ready_q;
    assign mm_enable = mm_enable_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_matmul_operand_loader.sv
// Scoreboard bench for matmul_operand_loader with a simple engine responder.
module tb_matmul_operand_loader;
    import matmul_pkg::*;

    localparam int CW = int'(MEM_W);

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [TYPE_BW-1:0] s_data = '0;
    logic               s_valid = 1'b0;
    logic               s_last = 1'b0;
    logic               s_ready;
    logic [MEM_W-1:0]   mem_o;
    logic               mm_enable;
    logic               mm_done = 1'b1;
    logic               busy;
    logic               err;
    logic               clear_err = 1'b0;

    matmul_operand_loader dut (
        .clk      (clk),
        .reset    (reset),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .mem_o    (mem_o),
        .mm_enable(mm_enable),
        .mm_done  (mm_done),
        .busy     (busy),
        .err      (err),
        .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_err;
        logic [CW-1:0] img;
    } exp_t;

    exp_t               exp_q[$];
    logic [TYPE_BW-1:0] exp_mem [IN_MEM_SIZE];
    int                 n_chk = 0;
    int                 n_err = 0;
    int                 eng_len = 4;
    int                 eng_cnt = 0;

    task automatic check(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Engine model: done falls shortly after enable rises, returns after eng_len cycles
    always @(posedge clk) begin
        if (!mm_enable) begin
            mm_done <= 1'b1;
            eng_cnt <= 0;
        end else begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt == 1) mm_done <= 1'b0;
            else if (eng_cnt == 1 + eng_len) mm_done <= 1'b1;
        end
    end

    // Monitor: pops expectations on job start / error, and watches the run window
    logic          mm_en_prev = 1'b0;
    logic          err_prev = 1'b0;
    logic [CW-1:0] mem_prev = '0;
    exp_t          mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            if ((mm_enable && !mm_en_prev) || (err && !err_prev)) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_event: enable=%0b err=%0b with empty scoreboard", mm_enable, err);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("job_outcome_is_err", CW'(err), CW'(mon_e.is_err));
                    if (!mon_e.is_err) check("mem_image", mem_o, mon_e.img);
                end
            end
            if (mm_enable && mm_en_prev) begin
                check("run_ready_low", CW'(s_ready), CW'(0));
                check("run_mem_stable", mem_o, mem_prev);
            end
        end
        mm_en_prev <= mm_enable;
        err_prev   <= err;
        mem_prev   <= mem_o;
    end

    function automatic logic [CW-1:0] pack_img();
        logic [CW-1:0] img;
        for (int i = 0; i < int'(IN_MEM_SIZE); i++) img[i*TYPE_BW +: TYPE_BW] = exp_mem[i];
        return img;
    endfunction

    // Reference: outcome of a word stream and how many leading words land in memory
    function automatic void model_job(input logic [15:0] w[$], input bit l[$],
                                      output bit ok, output int nwr);
        int unsigned need;
        need = 0;
        ok   = 1'b0;
        nwr  = w.size();
        for (int i = 0; i < w.size(); i++) begin
            if (i == 5) begin
                need = 32'd6 + 32'(w[1]) * 32'(w[2]) + 32'(w[3]) * 32'(w[4]);
                if (need > 32'd64) begin
                    nwr = 5;
                    return;
                end
            end
            if (i < 5) begin
                if (l[i]) begin
                    nwr = i;
                    return;
                end
            end else if (i == int'(need) - 1) begin
                ok  = l[i];
                nwr = l[i] ? i + 1 : i;
                return;
            end else if (l[i]) begin
                nwr = i;
                return;
            end
        end
    endfunction

    task automatic make_job(input int wa, input int ha, input int wb, input int hb, input int extra,
                            output logic [15:0] w[$], output bit l[$]);
        int n;
        w = {};
        l = {};
        w.push_back(16'($urandom));
        w.push_back(16'(wa));
        w.push_back(16'(ha));
        w.push_back(16'(wb));
        w.push_back(16'(hb));
        w.push_back(16'($urandom));
        n = wa * ha + wb * hb + extra;
        for (int i = 0; i < n; i++) w.push_back(16'($urandom));
        for (int i = 0; i < w.size(); i++) l.push_back(i == w.size() - 1);
    endtask

    task automatic send_word(input logic [15:0] d, input bit last, input bit throttle);
        int guard;
        if (throttle && $urandom_range(1, 0) == 1) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        guard   = 0;
        while (!s_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) check("send_timeout", CW'(s_ready), CW'(1));
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_job(input logic [15:0] w[$], input bit l[$], input bit throttle,
                           input int clr_at, input bit wait_done);
        bit   ok;
        int   nwr;
        int   guard;
        exp_t e;
        model_job(w, l, ok, nwr);
        for (int i = 0; i < nwr; i++) exp_mem[i] = w[i];
        e.is_err = !ok;
        e.img    = pack_img();
        exp_q.push_back(e);
        for (int i = 0; i < w.size(); i++) begin
            clear_err = (i == clr_at);
            send_word(w[i], l[i], throttle);
        end
        clear_err = 1'b0;
        if (ok) begin
            check("enable_latency", CW'(mm_enable), CW'(1));
            if (!wait_done) return;
            guard = 0;
            while (mm_enable && guard < 400) begin
                @(negedge clk);
                guard++;
            end
            check("rel_enable_low", CW'(mm_enable), CW'(0));
            check("rel_done_seen", CW'(mm_done), CW'(1));
            check("rel_busy", CW'(busy), CW'(1));
            @(negedge clk);
            check("idle_busy", CW'(busy), CW'(0));
            check("idle_ready", CW'(s_ready), CW'(1));
        end else begin
            guard = 0;
            while (!err && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            check("err_set", CW'(err), CW'(1));
            check("err_no_enable", CW'(mm_enable), CW'(0));
            clear_err = 1'b1;
            @(negedge clk);
            clear_err = 1'b0;
            check("err_cleared", CW'(err), CW'(0));
            check("cleared_ready", CW'(s_ready), CW'(1));
            check("cleared_busy", CW'(busy), CW'(0));
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("wait_idle", CW'(busy), CW'(0));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w[$];
        bit          l[$];
        int          guard;
        int          j;

        for (int i = 0; i < int'(IN_MEM_SIZE); i++) exp_mem[i] = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", CW'(s_ready), CW'(1));
        check("rst_enable", CW'(mm_enable), CW'(0));
        check("rst_busy", CW'(busy), CW'(0));
        check("rst_err", CW'(err), CW'(0));
        check("rst_mem", mem_o, CW'(0));
        reset = 1'b0;
        @(negedge clk);

        // clear_err outside ERR does nothing
        clear_err = 1'b1;
        repeat (2) @(negedge clk);
        clear_err = 1'b0;
        check("idle_clr_ready", CW'(s_ready), CW'(1));
        check("idle_clr_busy", CW'(busy), CW'(0));
        check("idle_clr_err", CW'(err), CW'(0));

        // Directed 2x2 * 2x2 job, A=1..4, B=5..8, stray clear_err mid-load
        eng_len = 4;
        make_job(2, 2, 2, 2, 0, w, l);
        for (int k = 0; k < 8; k++) w[6 + k] = 16'(k + 1);
        run_job(w, l, 1'b0, 7, 1'b1);

        // Oversized header: 8x8 * 8x8, later words dropped
        make_job(8, 8, 8, 8, 0, w, l);
        w = w[0:19];
        l = l[0:19];
        l[19] = 1'b1;
        run_job(w, l, 1'b0, -1, 1'b1);

        // Valid job after clearing, with throttled valid
        make_job(2, 2, 2, 2, 0, w, l);
        run_job(w, l, 1'b1, -1, 1'b1);

        // s_last on word 9 of a 2x2 job
        make_job(2, 2, 2, 2, 0, w, l);
        l[9] = 1'b1;
        run_job(w, l, 1'b0, -1, 1'b1);

        // Zero-size jobs: legal last on word 5, then missing last
        make_job(0, 3, 0, 5, 0, w, l);
        run_job(w, l, 1'b0, -1, 1'b1);
        make_job(0, 3, 0, 5, 0, w, l);
        l[5] = 1'b0;
        run_job(w, l, 1'b0, -1, 1'b1);

        // Words offered while the engine runs must not be taken
        eng_len = 20;
        make_job(2, 2, 2, 2, 0, w, l);
        run_job(w, l, 1'b1, -1, 1'b0);
        repeat (2) @(negedge clk);
        s_valid = 1'b1;
        s_data  = 16'hdead;
        repeat (4) begin
            @(negedge clk);
            check("offer_during_run", CW'(s_ready), CW'(0));
        end
        s_valid = 1'b0;
        wait_idle();

        // Random jobs with throttling and occasional framing faults
        for (int n = 0; n < 30; n++) begin
            eng_len = $urandom_range(8, 1);
            make_job($urandom_range(6, 0), $urandom_range(6, 0), $urandom_range(6, 0),
                     $urandom_range(6, 0), 0, w, l);
            if ($urandom_range(4, 0) == 0) begin
                j = $urandom_range(w.size() - 1, 0);
                l[j] = !l[j];
            end
            run_job(w, l, 1'b1, -1, 1'b1);
        end

        // Reset in the middle of a run
        eng_len = 30;
        make_job(2, 2, 2, 2, 0, w, l);
        run_job(w, l, 1'b0, -1, 1'b0);
        guard = 0;
        while (mm_done && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("run_reached", CW'(mm_done), CW'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrun_rst_enable", CW'(mm_enable), CW'(0));
        check("midrun_rst_mem", mem_o, CW'(0));
        check("midrun_rst_ready", CW'(s_ready), CW'(1));
        check("midrun_rst_busy", CW'(busy), CW'(0));
        reset = 1'b0;
        for (int i = 0; i < int'(IN_MEM_SIZE); i++) exp_mem[i] = '0;
        repeat (2) @(negedge clk);

        // Fresh job after reset
        eng_len = 3;
        make_job(1, 3, 3, 2, 0, w, l);
        run_job(w, l, 1'b1, -1, 1'b1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", CW'(exp_q.size()), CW'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
